// File: rtl/fib_result_writer.sv
// ============================================================================
// Module   : fib_result_writer
// Purpose  : Buffers Fibonacci results in a small FIFO and streams them to the
//            result memory with auto-incrementing address and ready handshake.
//            Optional macro FIB_RES_SEQ_CHECK_EN adds a monotonic-order check.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fib_result_writer #(
    parameter int DATA_WIDTH  = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int ADDR_WIDTH  = 8,
    parameter int MAX_RESULTS = 64
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] fib_in,
    input  logic                  new_fib_res,
    input  logic                  prog_ack,
    input  logic                  mem_ready,
    output logic [DATA_WIDTH-1:0] fib_out,
    output logic [ADDR_WIDTH-1:0] res_addr,
    output logic                  w_en_res,
    output logic [ADDR_WIDTH:0]   res_count,
    output logic                  overflow,
    output logic                  seq_err,
    output logic                  fib_written
);

    localparam int C_PTR_AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [C_PTR_AW:0]   C_DEPTH    = (C_PTR_AW+1)'(FIFO_DEPTH);
    localparam logic [C_PTR_AW:0]   C_PTR_ONE  = (C_PTR_AW+1)'(1);
    localparam logic [ADDR_WIDTH:0] C_MAX      = (ADDR_WIDTH+1)'(MAX_RESULTS);
    localparam logic [ADDR_WIDTH:0] C_CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] C_ADDR_ONE = ADDR_WIDTH'(1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [C_PTR_AW:0]     r_wr_ptr;
    logic [C_PTR_AW:0]     r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_last;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [ADDR_WIDTH:0]   r_accepted;
    logic                  r_overflow;

    logic [C_PTR_AW:0]     w_level;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_active;
    logic                  w_wen;
    logic                  w_pop;
    logic                  w_push_req;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_start;

    assign w_level    = r_wr_ptr - r_rd_ptr;
    assign w_empty    = (w_level == '0);
    assign w_full     = (w_level == C_DEPTH);
    assign w_active   = (r_state == S_COLLECT) || (r_state == S_DRAIN);
    assign w_wen      = w_active && !w_empty;
    assign w_pop      = w_wen && mem_ready;
    assign w_start    = (r_state == S_IDLE) && start;
    assign w_push_req = (r_state == S_COLLECT) && new_fib_res;
    // A full FIFO still takes a push when its head leaves in the same cycle.
    assign w_push     = w_push_req && (!w_full || w_pop) && (r_accepted < C_MAX);
    assign w_drop     = w_push_req && !w_push;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (start)    w_state_nxt = S_COLLECT;
            S_COLLECT: if (prog_ack) w_state_nxt = S_DRAIN;
            S_DRAIN:   if (w_empty)  w_state_nxt = S_DONE;
            S_DONE:                  w_state_nxt = S_IDLE;
            default:                 w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_last     <= '0;
            r_addr     <= '0;
            r_count    <= '0;
            r_accepted <= '0;
            r_overflow <= 1'b0;
        end else if (w_start) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_addr     <= '0;
            r_count    <= '0;
            r_accepted <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
                r_addr   <= r_addr + C_ADDR_ONE;
                r_count  <= r_count + C_CNT_ONE;
                r_last   <= r_mem[r_rd_ptr[C_PTR_AW-1:0]];
            end
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + C_PTR_ONE;
                r_accepted <= r_accepted + C_CNT_ONE;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only read while the pointers say valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[C_PTR_AW-1:0]] <= fib_in;
        end
    end

`ifdef FIB_RES_SEQ_CHECK_EN
    logic [DATA_WIDTH-1:0] r_prev;
    logic                  r_have_prev;
    logic                  r_seq_err;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_prev      <= '0;
            r_have_prev <= 1'b0;
            r_seq_err   <= 1'b0;
        end else if (w_start) begin
            r_have_prev <= 1'b0;
            r_seq_err   <= 1'b0;
        end else if (w_push) begin
            if (r_have_prev && (fib_in < r_prev)) begin
                r_seq_err <= 1'b1;
            end
            r_prev      <= fib_in;
            r_have_prev <= 1'b1;
        end
    end

    assign seq_err = r_seq_err;
`else
    assign seq_err = 1'b0;
`endif

    // When empty, the last written word stays on the bus.
    assign fib_out     = w_empty ? r_last : r_mem[r_rd_ptr[C_PTR_AW-1:0]];
    assign res_addr    = r_addr;
    assign w_en_res    = w_wen;
    assign res_count   = r_count;
    assign overflow    = r_overflow;
    assign fib_written = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_fib_result_writer.sv
// ============================================================================
// Module   : tb_fib_result_writer
// Purpose  : Self-checking bench for fib_result_writer against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fib_result_writer;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 3;
    localparam int MAXR  = 8;

    logic          clk = 1'b0;
    logic          arst_n;
    logic          start;
    logic [DW-1:0] fib_in;
    logic          new_fib_res;
    logic          prog_ack;
    logic          mem_ready;
    logic [DW-1:0] fib_out;
    logic [AW-1:0] res_addr;
    logic          w_en_res;
    logic [AW:0]   res_count;
    logic          overflow;
    logic          seq_err;
    logic          fib_written;

    fib_result_writer #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .ADDR_WIDTH (AW),
        .MAX_RESULTS(MAXR)
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .start      (start),
        .fib_in     (fib_in),
        .new_fib_res(new_fib_res),
        .prog_ack   (prog_ack),
        .mem_ready  (mem_ready),
        .fib_out    (fib_out),
        .res_addr   (res_addr),
        .w_en_res   (w_en_res),
        .res_count  (res_count),
        .overflow   (overflow),
        .seq_err    (seq_err),
        .fib_written(fib_written)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 collecting, 2 draining, 3 done.
    int            ph;
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_last;
    int            m_addr, m_count, m_acc;
    bit            m_ovf, m_seq;
`ifdef FIB_RES_SEQ_CHECK_EN
    logic [DW-1:0] m_prev;
    bit            m_have_prev;
`endif

    logic [AW+DW-1:0] wlog[$];
    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        ph = 0; m_last = '0; m_addr = 0; m_count = 0; m_acc = 0; m_ovf = 0; m_seq = 0;
    endtask

    task automatic check_outputs();
        bit en;
        en = (ph == 1 || ph == 2) && q.size() > 0;
        check("w_en_res", w_en_res, en);
        check("fib_out", fib_out, (q.size() > 0) ? q[0] : m_last);
        check("res_addr", res_addr, m_addr);
        check("res_count", res_count, m_count);
        check("overflow", overflow, m_ovf);
        check("seq_err", seq_err, m_seq);
        check("fib_written", fib_written, ph == 3);
        if (fib_written) n_done++;
    endtask

    task automatic model_step();
        bit en, pop, accept;
        int sz;
        en     = (ph == 1 || ph == 2) && q.size() > 0;
        pop    = en && mem_ready;
        sz     = q.size();
        accept = 0;
        case (ph)
            0: if (start) begin
                q.delete();
                m_addr = 0; m_count = 0; m_acc = 0; m_ovf = 0; m_seq = 0;
`ifdef FIB_RES_SEQ_CHECK_EN
                m_have_prev = 0;
`endif
                ph = 1;
            end
            1, 2: begin
                if (ph == 1 && new_fib_res) begin
                    if (m_acc < MAXR && (sz < DEPTH || pop)) accept = 1;
                    else m_ovf = 1;
                end
                if (pop) begin
                    m_last  = q.pop_front();
                    m_addr  = (m_addr + 1) % (1 << AW);
                    m_count = m_count + 1;
                end
                if (accept) begin
`ifdef FIB_RES_SEQ_CHECK_EN
                    if (m_have_prev && fib_in < m_prev) m_seq = 1;
                    m_prev = fib_in;
                    m_have_prev = 1;
`endif
                    q.push_back(fib_in);
                    m_acc++;
                end
                if (ph == 1) begin
                    if (prog_ack) ph = 2;
                end else if (sz == 0) begin
                    ph = 3;
                end
            end
            default: ph = 0;
        endcase
    endtask

    // One clock: check outputs at the falling edge, drive inputs, advance model.
    task automatic cycle(input bit s, input bit nf, input logic [DW-1:0] v,
                         input bit ack, input bit rdy);
        @(negedge clk);
        check_outputs();
        start = s; new_fib_res = nf; fib_in = v; prog_ack = ack; mem_ready = rdy;
        if (w_en_res && rdy) wlog.push_back({res_addr, fib_out});
        model_step();
    endtask

    task automatic finish_run(input bit toggle);
        for (int k = 0; k < 30 && ph != 0; k++)
            cycle(0, 0, '0, 0, toggle ? k[0] : 1'b1);
    endtask

    initial begin
        logic [DW-1:0] bv[5];
        logic [DW-1:0] base, v;
        int len, d0;
        bit incr, nf;

        bv = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3};
        arst_n = 1'b0; start = 0; new_fib_res = 0; fib_in = '0; prog_ack = 0; mem_ready = 0;
        model_reset();
        repeat (2) @(negedge clk);
        arst_n = 1'b1;

        // Basic run
        wlog.delete(); d0 = n_done;
        cycle(1, 0, '0, 0, 1);
        for (int i = 0; i < 5; i++) cycle(0, 1, bv[i], 0, 1);
        cycle(0, 0, '0, 1, 1);
        finish_run(0);
        cycle(0, 0, '0, 0, 1);
        check("basic_nwrites", wlog.size(), 5);
        for (int i = 0; i < 5 && i < wlog.size(); i++)
            check("basic_write", wlog[i], {AW'(i), bv[i]});
        check("basic_done_pulses", n_done - d0, 1);
        check("basic_count", res_count, 5);
        check("basic_ovf", overflow, 0);

        // Backpressure: 6 pushes into a 4-deep FIFO with the memory stalled
        wlog.delete();
        cycle(1, 0, '0, 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 1, DW'(10 + i), 0, 0);
        cycle(0, 0, '0, 0, 0);
        cycle(0, 0, '0, 0, 0);
        check("bp_ovf", overflow, 1);
        check("bp_addr", res_addr, 0);
        check("bp_data", fib_out, 10);
        check("bp_wen", w_en_res, 1);
        cycle(0, 0, '0, 1, 1);
        finish_run(0);
        cycle(0, 0, '0, 0, 1);
        check("bp_count", res_count, 4);

        // Full FIFO with simultaneous pop accepts the push
        wlog.delete();
        cycle(1, 0, '0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, DW'(20 + i), 0, 0);
        cycle(0, 1, 32'd99, 0, 1);
        cycle(0, 0, '0, 1, 1);
        finish_run(0);
        cycle(0, 0, '0, 0, 1);
        check("fullpop_ovf", overflow, 0);
        check("fullpop_count", res_count, 5);
        check("fullpop_last", wlog.size() == 5 ? wlog[4][DW-1:0] : '0, 99);

        // Result limit and address wrap
        wlog.delete();
        cycle(1, 0, '0, 0, 1);
        for (int i = 0; i < MAXR + 2; i++) cycle(0, 1, DW'(100 + i), 0, 1);
        cycle(0, 0, '0, 1, 1);
        finish_run(0);
        cycle(0, 0, '0, 0, 1);
        check("lim_count", res_count, MAXR);
        check("lim_addr_wrap", res_addr, 0);
        check("lim_ovf", overflow, 1);
        for (int i = 0; i < MAXR && i < wlog.size(); i++)
            check("lim_write", wlog[i], {AW'(i), DW'(100 + i)});

        // Drain with toggling ready
        wlog.delete(); d0 = n_done;
        cycle(1, 0, '0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, DW'(40 + i), 0, 0);
        cycle(0, 0, '0, 1, 0);
        finish_run(1);
        cycle(0, 0, '0, 0, 0);
        check("drain_nwrites", wlog.size(), 3);
        check("drain_done_pulses", n_done - d0, 1);

        // Sequence check: 5 then 3
        wlog.delete();
        cycle(1, 0, '0, 0, 0);
        cycle(0, 1, 32'd5, 0, 0);
        cycle(0, 1, 32'd3, 0, 0);
        cycle(0, 0, '0, 1, 1);
        finish_run(0);
        cycle(0, 0, '0, 0, 1);
`ifdef FIB_RES_SEQ_CHECK_EN
        check("seq_flag", seq_err, 1);
`else
        check("seq_flag", seq_err, 0);
`endif
        check("seq_nwrites", wlog.size(), 2);

        // Randomized runs
        for (int r = 0; r < 20; r++) begin
            cycle(1, 0, '0, 0, $urandom_range(0, 1) == 1);
            len  = $urandom_range(0, 25);
            incr = ($urandom_range(0, 1) == 1);
            base = $urandom_range(0, 1000);
            for (int k = 0; k < len; k++) begin
                nf = ($urandom_range(0, 9) < 6);
                v  = incr ? base : $urandom;
                if (incr && nf) base = base + $urandom_range(0, 3);
                cycle($urandom_range(0, 9) == 0, nf, v, 0, $urandom_range(0, 9) < 7);
            end
            cycle(0, $urandom_range(0, 1) == 1, $urandom, 1, $urandom_range(0, 1) == 1);
            for (int k = 0; k < 40 && ph != 0; k++)
                cycle($urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, $urandom,
                      $urandom_range(0, 1) == 1, (k > 20) || ($urandom_range(0, 1) == 1));
            cycle(0, 0, '0, 0, 1);
        end

        // Asynchronous reset mid-drain
        cycle(1, 0, '0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, DW'(70 + i), 0, 0);
        cycle(0, 0, '0, 1, 1);
        cycle(0, 0, '0, 0, 0);
        @(posedge clk);
        #2 arst_n = 1'b0;
        #1;
        check("rst_w_en", w_en_res, 0);
        check("rst_fib_out", fib_out, 0);
        check("rst_addr", res_addr, 0);
        check("rst_count", res_count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_seq", seq_err, 0);
        check("rst_written", fib_written, 0);
        model_reset();
        start = 0; new_fib_res = 0; prog_ack = 0; mem_ready = 0;
        @(negedge clk);
        arst_n = 1'b1;
        for (int i = 0; i < 4; i++)
            cycle(0, 1, $urandom, $urandom_range(0, 1) == 1, 1);
        cycle(1, 0, '0, 0, 1);
        cycle(0, 1, 32'd7, 1, 1);
        finish_run(0);

        @(negedge clk);
        check_outputs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
